// File: rtl/dmac_xfer_engine.sv
// Per-channel DMA transfer engine: moves Trans_Count beats as a
// non-pipelined AHB-Lite master, one read then one write per beat.
module dmac_xfer_engine #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Channel_en,
    input  logic [ADDR_W-1:0] Src_Addr,
    input  logic [ADDR_W-1:0] Dst_Addr,
    input  logic [CNT_W-1:0]  Trans_Count,
    input  logic              Src_Inc,
    input  logic              Dst_Inc,
    input  logic [2:0]        Size_In,
    input  logic              HReady,
    input  logic              HResp,
    input  logic [DATA_W-1:0] HRData,
    output logic [ADDR_W-1:0] HAddr,
    output logic [1:0]        HTrans,
    output logic              HWrite,
    output logic [2:0]        HSize,
    output logic [DATA_W-1:0] HWData,
    output logic              busy,
    output logic              irq,
    output logic              err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_ADDR = 3'd1;
    localparam logic [2:0] S_RD_DATA = 3'd2;
    localparam logic [2:0] S_WR_ADDR = 3'd3;
    localparam logic [2:0] S_WR_DATA = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]        state;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] data;
    logic [1:0]        size;
    logic              src_inc;
    logic              dst_inc;
    logic              err_q;
    logic [1:0]        size_lat;
    logic [ADDR_W-1:0] step;

    // Encodings above word are clamped to word
    assign size_lat = (Size_In > 3'd2) ? 2'd2 : Size_In[1:0];
    assign step     = ADDR_W'(1) << size;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            src     <= '0;
            dst     <= '0;
            cnt     <= '0;
            data    <= '0;
            size    <= '0;
            src_inc <= 1'b0;
            dst_inc <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (Channel_en) begin
                        src     <= Src_Addr;
                        dst     <= Dst_Addr;
                        cnt     <= Trans_Count;
                        size    <= size_lat;
                        src_inc <= Src_Inc;
                        dst_inc <= Dst_Inc;
                        err_q   <= 1'b0;
                        state   <= (Trans_Count == '0) ? S_DONE : S_RD_ADDR;
                    end
                end
                S_RD_ADDR: begin
                    if (HReady) state <= S_RD_DATA;
                end
                S_RD_DATA: begin
                    if (HReady) begin
                        if (HResp) begin
                            err_q <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            data  <= HRData;
                            state <= S_WR_ADDR;
                        end
                    end
                end
                S_WR_ADDR: begin
                    if (HReady) state <= S_WR_DATA;
                end
                S_WR_DATA: begin
                    if (HReady) begin
                        if (HResp) begin
                            err_q <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                            if (src_inc) src <= src + step;
                            if (dst_inc) dst <= dst + step;
                            state <= (cnt == CNT_W'(1)) ? S_DONE : S_RD_ADDR;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Bus outputs decode from state and registers only
    always_comb begin
        HAddr  = '0;
        HTrans = 2'b00;
        HWrite = 1'b0;
        busy   = 1'b0;
        unique case (state)
            S_RD_ADDR: begin
                HAddr  = src;
                HTrans = 2'b10;
                busy   = 1'b1;
            end
            S_RD_DATA: begin
                HAddr = src;
                busy  = 1'b1;
            end
            S_WR_ADDR: begin
                HAddr  = dst;
                HTrans = 2'b10;
                HWrite = 1'b1;
                busy   = 1'b1;
            end
            S_WR_DATA: begin
                HAddr = dst;
                busy  = 1'b1;
            end
            default: begin
                HAddr  = '0;
                HTrans = 2'b00;
                HWrite = 1'b0;
                busy   = 1'b0;
            end
        endcase
    end

    assign HSize  = {1'b0, size};
    assign HWData = data;
    assign irq    = (state == S_DONE);
    assign err    = err_q;

endmodule

// File: tb/tb_dmac_xfer_engine.sv
// Bench for dmac_xfer_engine: AHB slave with random wait states and
// error injection, checked against a transfer-list reference model.
module tb_dmac_xfer_engine;

    logic        clk;
    logic        rst;
    logic        Channel_en;
    logic [31:0] Src_Addr;
    logic [31:0] Dst_Addr;
    logic [15:0] Trans_Count;
    logic        Src_Inc;
    logic        Dst_Inc;
    logic [2:0]  Size_In;
    logic        HReady;
    logic        HResp;
    logic [31:0] HRData;
    logic [31:0] HAddr;
    logic [1:0]  HTrans;
    logic        HWrite;
    logic [2:0]  HSize;
    logic [31:0] HWData;
    logic        busy;
    logic        irq;
    logic        err;

    int errs = 0;
    int checks = 0;

    dmac_xfer_engine #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .Channel_en(Channel_en),
        .Src_Addr(Src_Addr), .Dst_Addr(Dst_Addr),
        .Trans_Count(Trans_Count), .Src_Inc(Src_Inc), .Dst_Inc(Dst_Inc),
        .Size_In(Size_In), .HReady(HReady), .HResp(HResp),
        .HRData(HRData), .HAddr(HAddr), .HTrans(HTrans),
        .HWrite(HWrite), .HSize(HSize), .HWData(HWData),
        .busy(busy), .irq(irq), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] memv(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endfunction

    task automatic chk_reset_vals();
        chk("rst_haddr", HAddr, 0);
        chk("rst_htrans", HTrans, 0);
        chk("rst_hwrite", HWrite, 0);
        chk("rst_hsize", HSize, 0);
        chk("rst_hwdata", HWData, 0);
        chk("rst_busy", busy, 0);
        chk("rst_irq", irq, 0);
        chk("rst_err", err, 0);
    endtask

    // wp < 0 selects exactly two stall cycles in every bus phase
    task automatic run_xfer(input logic [31:0] s, input logic [31:0] d,
                            input int c, input bit si, input bit di,
                            input logic [2:0] szi, input int eb,
                            input bit ew, input int wp);
        logic [31:0] ea[$];
        bit          ewq[$];
        logic [31:0] ed[$];
        logic [1:0]  sz;
        logic [31:0] st;
        logic [31:0] daddr;
        int ph, waits, op, rb, wb, stl, dph;
        bit got, rdy, ee;
        sz = (szi > 3'd2) ? 2'd2 : szi[1:0];
        st = 32'd1 << sz;
        ph = 0; waits = 0; op = 0; rb = 0; wb = 0; stl = 2; dph = 0;
        daddr = '0; got = 0;
        ee = (eb >= 0) && (eb < c);
        for (int i = 0; i < c; i++) begin
            logic [31:0] ra, wa;
            ra = s + (si ? st * 32'(i) : 32'd0);
            wa = d + (di ? st * 32'(i) : 32'd0);
            ea.push_back(ra); ewq.push_back(1'b0); ed.push_back('0);
            if (eb == i && !ew) begin
                ph += 2;
                break;
            end
            ea.push_back(wa); ewq.push_back(1'b1); ed.push_back(memv(ra));
            ph += 4;
            if (eb == i) break;
        end
        Src_Addr = s; Dst_Addr = d; Trans_Count = 16'(c);
        Src_Inc = si; Dst_Inc = di; Size_In = szi;
        HReady = 1'b1; HResp = 1'b0; Channel_en = 1'b1;
        @(negedge clk);
        chk("err_clr", err, 0);
        for (int n = 1; n <= 400; n++) begin
            Channel_en = 1'b0;
            HResp = 1'b0;
            if (irq) begin
                chk("irq_cyc", n, ph + waits + 1);
                chk("err", err, ee);
                chk("ops", op, ea.size());
                got = 1;
                break;
            end
            if (HTrans == 2'b10) begin
                if (op < ea.size()) begin
                    chk("haddr", HAddr, ea[op]);
                    chk("hwrite", HWrite, ewq[op]);
                    chk("hsize", HSize, {1'b0, sz});
                end else begin
                    chk("extra_nonseq", 1, 0);
                end
            end else if (HTrans != 2'b00) begin
                chk("htrans", HTrans, 0);
            end
            rdy = 1'b1;
            if (busy) begin
                if (wp < 0) begin
                    rdy = (stl == 0);
                    if (!rdy) stl--;
                    else stl = 2;
                end else begin
                    rdy = ($urandom_range(99) >= wp);
                end
                if (!rdy) waits++;
            end
            if (dph == 1) begin
                HRData = memv(daddr);
                HResp = rdy && !ew && (rb - 1 == eb);
            end
            if (dph == 2) begin
                HResp = rdy && ew && (wb - 1 == eb);
                if (rdy && op > 0 && op <= ed.size())
                    chk("hwdata", HWData, ed[op-1]);
            end
            if (rdy && dph != 0) dph = 0;
            if (rdy && HTrans == 2'b10) begin
                dph = HWrite ? 2 : 1;
                daddr = HAddr;
                op++;
                if (HWrite) wb++;
                else rb++;
            end
            HReady = rdy;
            if (busy && $urandom_range(5) == 0) begin
                Channel_en = 1'b1;
                Src_Addr = $urandom;
                Dst_Addr = $urandom;
                Trans_Count = 16'($urandom);
                Size_In = 3'($urandom);
            end
            @(negedge clk);
        end
        if (!got) chk("irq_timeout", 0, 1);
        Channel_en = 1'b0; HReady = 1'b1; HResp = 1'b0;
        @(negedge clk);
        chk("irq_pulse", irq, 0);
        chk("idle_busy", busy, 0);
        chk("err_hold", err, ee);
        chk("idle_htrans", HTrans, 0);
    endtask

    task automatic reset_mid();
        bit seen;
        Src_Addr = 32'h300; Dst_Addr = 32'h400; Trans_Count = 16'd2;
        Src_Inc = 1'b1; Dst_Inc = 1'b1; Size_In = 3'd2;
        HReady = 1'b1; HResp = 1'b0; HRData = 32'h1234_5678;
        Channel_en = 1'b1;
        @(negedge clk);
        Channel_en = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (HTrans == 2'b10 && HWrite) break;
            @(negedge clk);
        end
        chk("wr_addr_reached", (HTrans == 2'b10) && HWrite, 1);
        #2 rst = 1'b1;
        #1 chk_reset_vals();
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (irq) seen = 1;
        end
        chk("rst_no_irq", seen, 0);
        chk("rst_idle", busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        Channel_en = 1'b0; Src_Addr = '0; Dst_Addr = '0;
        Trans_Count = '0; Src_Inc = 1'b0; Dst_Inc = 1'b0;
        Size_In = '0; HReady = 1'b1; HResp = 1'b0; HRData = '0;
        #12 chk_reset_vals();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_xfer(32'h100, 32'h200, 1, 1, 1, 3'd2, -1, 0, 0);
        run_xfer(32'h100, 32'h200, 3, 1, 0, 3'd1, -1, 0, 0);
        run_xfer(32'h100, 32'h200, 1, 1, 1, 3'd2, -1, 0, -1);
        run_xfer(32'h500, 32'h600, 4, 1, 1, 3'd2, 1, 0, 0);
        repeat (3) @(negedge clk);
        chk("err_sticky", err, 1);
        run_xfer(32'h700, 32'h800, 0, 1, 1, 3'd2, -1, 0, 0);
        run_xfer(32'h900, 32'hA00, 3, 1, 1, 3'd0, 2, 1, 20);
        run_xfer(32'hFFFF_FFFC, 32'hFFFF_FFFE, 3, 1, 1, 3'd7, -1, 0, 0);
        reset_mid();
        run_xfer(32'h100, 32'h200, 2, 1, 1, 3'd2, -1, 0, 0);

        for (int t = 0; t < 25; t++) begin
            logic [31:0] s, d;
            int c, eb;
            c = $urandom_range(0, 6);
            s = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 : $urandom;
            d = $urandom;
            eb = ($urandom_range(3) == 0) ? $urandom_range(0, c) : -1;
            run_xfer(s, d, c, 1'($urandom), 1'($urandom), 3'($urandom),
                     eb, 1'($urandom), $urandom_range(0, 40));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/dmac_xfer_engine.md
Name: dmac_xfer_engine

Overview:
- Per-channel transfer engine downstream of the DMAC main controller.
- Enabled by the controller's Channel_en pulse, it moves Trans_Count beats from source to destination as an AHB-Lite master, one beat at a time: read then write, non-pipelined.
- Raises `irq` on completion or bus error, which the main controller consumes to raise Interrupt and return to IDLE.

Parameters:
- ADDR_W, 32, AHB address width.
- DATA_W, 32, AHB data width.
- CNT_W, 16, transfer-count width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- Channel_en  in  1  start pulse from main controller.
- Src_Addr  in  ADDR_W  source start address, sampled at start.
- Dst_Addr  in  ADDR_W  destination start address, sampled at start.
- Trans_Count  in  CNT_W  beats to move, sampled at start.
- Src_Inc  in  1  1 = increment source address per beat, 0 = fixed (peripheral FIFO).
- Dst_Inc  in  1  same, for destination.
- Size_In  in  3  beat size encoding; 0 = byte, 1 = half, 2 = word; values >2 are treated as 2.
- HReady  in  1  AHB ready.
- HResp  in  1  AHB response; 1 = ERROR.
- HRData  in  DATA_W  AHB read data.
- HAddr  out  ADDR_W  AHB address.
- HTrans  out  2  2'b00 IDLE, 2'b10 NONSEQ.
- HWrite  out  1  AHB write.
- HSize  out  3  AHB size, the latched size.
- HWData  out  DATA_W  AHB write data.
- busy  out  1  transfer in progress.
- irq  out  1  one-cycle completion/error pulse.
- err  out  1  sticky bus-error flag; cleared by the next accepted start.

Behaviour:
- Reset values (async, rst=1): state IDLE; HAddr=0, HTrans=00, HWrite=0, HSize=0, HWData=0, busy=0, irq=0, err=0; internal count, address and data registers = 0.
- State register and all datapath registers are flops.
- AHB outputs are a Moore decode of state plus registers. No combinational path from any input to any output.
- IDLE:
  - busy=0.
  - Channel_en=1: latch Src_Addr, Dst_Addr, Trans_Count and size; clear err.
  - Go to DONE if Trans_Count==0, else RD_ADDR.
- RD_ADDR:
  - HAddr=src, HTrans=NONSEQ, HWrite=0.
  - Hold until HReady=1, then go to RD_DATA.
- RD_DATA:
  - HTrans=IDLE. Wait for HReady=1.
  - If HResp=0: capture HRData into the data register, go to WR_ADDR.
  - If HResp=1: set err, go to DONE. No write is issued.
- WR_ADDR:
  - HAddr=dst, HTrans=NONSEQ, HWrite=1.
  - Hold until HReady=1, then go to WR_DATA.
- WR_DATA:
  - HTrans=IDLE, HWData=data register. Wait for HReady=1.
  - On HResp=1: set err, go to DONE.
  - On HResp=0, in the same edge:
    - count decrements by 1.
    - src increments by (1<<size) if Src_Inc.
    - dst increments by (1<<size) if Dst_Inc.
    - Go to DONE if the pre-decrement count==1, else RD_ADDR.
- DONE:
  - irq=1 for exactly this one cycle; busy=0.
  - Next state is IDLE unconditionally.
- busy=1 in RD_ADDR, RD_DATA, WR_ADDR and WR_DATA.
- Channel_en while not in IDLE is ignored; configuration is not re-latched.
- Addresses wrap modulo 2^ADDR_W. Alignment is not checked.
- Minimum latency: one beat takes 4 cycles with zero wait states. Start in cycle 0 gives irq in cycle 5.
- rst mid-transfer: immediate return to IDLE with all outputs at reset values; no irq.

Test Plan:
- Single word: Src=0x100, Dst=0x200, Count=1, Inc=1/1, Size=2, HReady=1, HRData=0xDEADBEEF.
  - Required: read NONSEQ at 0x100, then write NONSEQ at 0x200 with HWData=0xDEADBEEF.
  - irq exactly one cycle, 5 cycles after start; err=0.
- Increment/fixed: Count=3, Src_Inc=1, Dst_Inc=0, Size=1.
  - Required: read addresses 0x100, 0x102, 0x104; all writes to 0x200.
  - Single irq after the third write data phase.
- Wait states: HReady=0 for 2 cycles in each address and data phase of a 1-beat transfer.
  - Required: HAddr/HTrans/HWrite held stable throughout each stall.
  - irq 8 cycles later than in the zero-wait case.
- Read error: HResp=1 in the RD_DATA phase of beat 2 of 4.
  - Required: no write for beat 2; err=1; irq pulse; back in IDLE.
  - err stays 1 until the next Channel_en.
- Zero count plus ignored start: Count=0 start.
  - Required: irq in the next cycle, no AHB NONSEQ.
  - A Channel_en pulse mid-transfer leaves the addresses and count unchanged.
- Async reset asserted during WR_ADDR.
  - Required: outputs immediately at reset values, HTrans=00, no irq.
  - A fresh start afterwards completes normally.
